// File: rtl/regfile_ctrl_pkg.sv
// Shared types and defaults for the register-file control blocks (scoreboard, bench, debug).
package regfile_ctrl_pkg;

    localparam int REG_NO_DEF   = 8;
    localparam int REG_IDX_W    = $clog2(REG_NO_DEF);
    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam int MAX_AGE_DEF  = 7;
    localparam int KILL_AGE_DEF = 2;
    localparam int AGE_W        = $clog2(MAX_AGE_DEF + 1);
    typedef logic [AGE_W-1:0] age_t;

    typedef enum logic [1:0] {
        HZ_NONE,
        HZ_RAW1,
        HZ_RAW2,
        HZ_WAW
    } hazard_e;

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue, writeback and status bundle between decode and the register scoreboard.
// stall_cnt is present only when REG_SCOREBOARD_PERF_EN is defined.
interface reg_scoreboard_if
    import regfile_ctrl_pkg::*;
#(
    parameter int REG_NO = REG_NO_DEF
);
    localparam int IW = $clog2(REG_NO);

    logic              issue_valid;
    logic [IW-1:0]     issue_rs1;
    logic [IW-1:0]     issue_rs2;
    logic              issue_rs1_use;
    logic              issue_rs2_use;
    logic [IW-1:0]     issue_rd;
    logic              issue_rd_we;
    logic              wb_valid;
    logic [IW-1:0]     wb_rd;
    logic              flush;
    logic              stall;
    logic [REG_NO-1:0] pending;
    logic              lost_err;
`ifdef REG_SCOREBOARD_PERF_EN
    logic [31:0]       stall_cnt;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_rs1_use, issue_rs2_use,
        output issue_rd, issue_rd_we, wb_valid, wb_rd, flush,
        input  stall, pending, lost_err, stall_cnt
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_rs1_use, issue_rs2_use,
        input  issue_rd, issue_rd_we, wb_valid, wb_rd, flush,
        output stall, pending, lost_err, stall_cnt
    );
`else
    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_rs1_use, issue_rs2_use,
        output issue_rd, issue_rd_we, wb_valid, wb_rd, flush,
        input  stall, pending, lost_err
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_rs1_use, issue_rs2_use,
        input  issue_rd, issue_rd_we, wb_valid, wb_rd, flush,
        output stall, pending, lost_err
    );
`endif

endinterface

// File: rtl/sb_entry.sv
// One scoreboard entry: pending bit plus age since issue, updated with
// priority set > young-flush kill > writeback clear > age increment.
module sb_entry
    import regfile_ctrl_pkg::*;
#(
    parameter int MAX_AGE  = MAX_AGE_DEF,
    parameter int KILL_AGE = KILL_AGE_DEF
) (
    input  logic Clk,
    input  logic Rst,
    input  logic set,
    input  logic flush,
    input  logic clr,
    output logic pend,
    output logic lost
);
    localparam int AW = $clog2(MAX_AGE + 1);

    logic          pend_reg;
    logic [AW-1:0] age_reg;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            pend_reg <= 1'b0;
            age_reg  <= '0;
        end else if (set) begin
            // A new writer wins over a same-cycle writeback of the older one.
            pend_reg <= 1'b1;
            age_reg  <= '0;
        end else if (flush && (age_reg < AW'(KILL_AGE))) begin
            pend_reg <= 1'b0;
            age_reg  <= '0;
        end else if (clr) begin
            pend_reg <= 1'b0;
            age_reg  <= '0;
        end else if (pend_reg && (age_reg != AW'(MAX_AGE))) begin
            age_reg  <= age_reg + 1'b1;
        end
    end

    assign pend = pend_reg;
    assign lost = pend_reg && (age_reg == AW'(MAX_AGE));

endmodule

// File: rtl/reg_scoreboard.sv
// In-order issue scoreboard: tracks outstanding register writes and stalls decode
// on RAW/WAW hazards not covered by the write bypass. REG_SCOREBOARD_PERF_EN adds stall_cnt.
module reg_scoreboard
    import regfile_ctrl_pkg::*;
#(
    parameter int REG_NO   = REG_NO_DEF,
    parameter int KILL_AGE = KILL_AGE_DEF,
    parameter int MAX_AGE  = MAX_AGE_DEF
) (
    input  logic            Clk,
    input  logic            Rst,
    reg_scoreboard_if.slave sb
);
    localparam int IW = $clog2(REG_NO);

    logic [REG_NO-1:0] pend;
    logic [REG_NO-1:0] lost_vec;
    logic              raw1;
    logic              raw2;
    logic              waw;
    hazard_e           hz;
    logic              stall;
    logic              issued;
    logic              lost_err_reg;

    assign pend[0]     = 1'b0;
    assign lost_vec[0] = 1'b0;

    for (genvar gi = 1; gi < REG_NO; gi++) begin : g_entry
        logic set_i;
        logic clr_i;

        assign set_i = issued && (sb.issue_rd == IW'(gi));
        assign clr_i = sb.wb_valid && (sb.wb_rd == IW'(gi));

        sb_entry #(
            .MAX_AGE  (MAX_AGE),
            .KILL_AGE (KILL_AGE)
        ) u_entry (
            .Clk   (Clk),
            .Rst   (Rst),
            .set   (set_i),
            .flush (sb.flush),
            .clr   (clr_i),
            .pend  (pend[gi]),
            .lost  (lost_vec[gi])
        );
    end

    // A register being written back this cycle is forwarded, so it is not a hazard.
    always_comb begin
        raw1 = sb.issue_rs1_use && (sb.issue_rs1 != '0) && pend[sb.issue_rs1]
               && !(sb.wb_valid && (sb.wb_rd == sb.issue_rs1));
        raw2 = sb.issue_rs2_use && (sb.issue_rs2 != '0) && pend[sb.issue_rs2]
               && !(sb.wb_valid && (sb.wb_rd == sb.issue_rs2));
        waw  = sb.issue_rd_we && (sb.issue_rd != '0) && pend[sb.issue_rd]
               && !(sb.wb_valid && (sb.wb_rd == sb.issue_rd));
        hz = HZ_NONE;
        if (raw1) begin
            hz = HZ_RAW1;
        end else if (raw2) begin
            hz = HZ_RAW2;
        end else if (waw) begin
            hz = HZ_WAW;
        end
    end

    assign stall  = Rst && sb.issue_valid && !sb.flush && (hz != HZ_NONE);
    assign issued = sb.issue_valid && !stall && !sb.flush && sb.issue_rd_we
                    && (sb.issue_rd != '0);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            lost_err_reg <= 1'b0;
        end else if (|lost_vec) begin
            lost_err_reg <= 1'b1;
        end
    end

    assign sb.stall    = stall;
    assign sb.pending  = pend;
    assign sb.lost_err = lost_err_reg;

`ifdef REG_SCOREBOARD_PERF_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            stall_cnt_reg <= '0;
        end else if (stall) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign sb.stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: reference model plus expected-pending queue.
`timescale 1ns/1ps
module tb_reg_scoreboard;
    import regfile_ctrl_pkg::*;

    localparam int NR = 8;
    localparam int KA = 2;
    localparam int MA = 7;
    localparam int IW = $clog2(NR);

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    always #5 Clk = ~Clk;

    reg_scoreboard_if #(.REG_NO(NR)) sbif ();

    reg_scoreboard #(
        .REG_NO   (NR),
        .KILL_AGE (KA),
        .MAX_AGE  (MA)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .sb  (sbif)
    );

    int n_checks = 0;
    int n_errors = 0;

    int m_pend [NR];
    int m_age  [NR];
    int m_stall_cnt = 0;
    logic [NR-1:0] exp_q [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NR-1:0] model_mask();
        logic [NR-1:0] m;
        m = '0;
        for (int i = 1; i < NR; i++) m[i] = (m_pend[i] != 0);
        return m;
    endfunction

    function automatic bit src_hz(input int s, input bit use_s, input bit wbv, input int wbrd);
        return use_s && (s != 0) && (m_pend[s] != 0) && !(wbv && (wbrd == s));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_pend[i] = 0;
            m_age[i]  = 0;
        end
        m_stall_cnt = 0;
    endtask

    task automatic clear_inputs();
        sbif.issue_valid   = 1'b0;
        sbif.issue_rs1     = '0;
        sbif.issue_rs2     = '0;
        sbif.issue_rs1_use = 1'b0;
        sbif.issue_rs2_use = 1'b0;
        sbif.issue_rd      = '0;
        sbif.issue_rd_we   = 1'b0;
        sbif.wb_valid      = 1'b0;
        sbif.wb_rd         = '0;
        sbif.flush         = 1'b0;
    endtask

    // One clock of stimulus: check stall against the model, queue next pending, compare after the edge.
    task automatic step(input string tag, input bit iv, input int rs1, input bit u1,
                        input int rs2, input bit u2, input int rd, input bit we,
                        input bit wbv, input int wbrd, input bit fl);
        bit exp_stall;
        bit issued;
        logic [NR-1:0] exp_pend;
        @(negedge Clk);
        sbif.issue_valid   = iv;
        sbif.issue_rs1     = IW'(rs1);
        sbif.issue_rs1_use = u1;
        sbif.issue_rs2     = IW'(rs2);
        sbif.issue_rs2_use = u2;
        sbif.issue_rd      = IW'(rd);
        sbif.issue_rd_we   = we;
        sbif.wb_valid      = wbv;
        sbif.wb_rd         = IW'(wbrd);
        sbif.flush         = fl;
        #1;
        exp_stall = iv && !fl && (src_hz(rs1, u1, wbv, wbrd) || src_hz(rs2, u2, wbv, wbrd)
                                  || src_hz(rd, we, wbv, wbrd));
        check_val({tag, ".stall"}, 32'(sbif.stall), 32'(exp_stall));
        issued = iv && !exp_stall && !fl && we && (rd != 0);
        if (exp_stall) m_stall_cnt++;
        for (int i = 1; i < NR; i++) begin
            if (issued && rd == i) begin
                m_pend[i] = 1;
                m_age[i]  = 0;
            end else if (fl && m_age[i] < KA) begin
                m_pend[i] = 0;
                m_age[i]  = 0;
            end else if (wbv && wbrd == i) begin
                m_pend[i] = 0;
                m_age[i]  = 0;
            end else if (m_pend[i] != 0 && m_age[i] < MA) begin
                m_age[i]++;
            end
        end
        exp_q.push_back(model_mask());
        @(posedge Clk);
        #1;
        exp_pend = exp_q.pop_front();
        check_val({tag, ".pend"}, 32'(sbif.pending), 32'(exp_pend));
        $display("txn %-8s iv=%0d rs1=%0d/%0d rs2=%0d/%0d rd=%0d/%0d wb=%0d/%0d fl=%0d stall=%0d pending=%02h",
                 tag, iv, rs1, u1, rs2, u2, rd, we, wbv, wbrd, fl, exp_stall, sbif.pending);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic iss(input string tag, input int rd);
        step(tag, 1, 0, 0, 0, 0, rd, 1, 0, 0, 0);
    endtask

    task automatic wbk(input string tag, input int rd);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 1, rd, 0);
    endtask

    initial begin
        model_reset();
        clear_inputs();
        #3;
        check_val("rst_pend", 32'(sbif.pending), 32'h0);
        check_val("rst_lost", 32'(sbif.lost_err), 32'h0);
        check_val("rst_stall", 32'(sbif.stall), 32'h0);
        @(negedge Clk);
        Rst = 1'b1;

        // Basic set / clear
        iss("rd3", 3);
        check_val("tp_rd3", 32'(sbif.pending), 32'h08);
        wbk("wb3", 3);
        check_val("tp_wb3", 32'(sbif.pending), 32'h00);

        // RAW: consumer stalls until producer writeback, then issues in that cycle
        iss("raw_p", 5);
        step("raw_s1", 1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
        step("raw_s2", 1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
        check_val("tp_raw_hold", 32'(sbif.stall), 32'h1);
        step("raw_go", 1, 5, 1, 0, 0, 6, 1, 1, 5, 0);
        check_val("tp_raw_go", 32'(sbif.pending), 32'h40);
        wbk("raw_wb", 6);

        // Same-cycle set and clear keeps the entry with a fresh age (young enough to be flushed)
        iss("sc_p", 2);
        step("sc_both", 1, 0, 0, 0, 0, 2, 1, 1, 2, 0);
        check_val("tp_sc_both", 32'(sbif.pending), 32'h04);
        idle("sc_idle");
        step("sc_fl", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        check_val("tp_sc_fl", 32'(sbif.pending), 32'h00);

        // WAW
        iss("waw_p", 7);
        step("waw_s", 1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
        step("waw_go", 1, 0, 0, 0, 0, 7, 1, 1, 7, 0);
        check_val("tp_waw_go", 32'(sbif.pending), 32'h80);
        wbk("waw_wb", 7);

        // Flush kills young entries only; no issue and no stall in the flush cycle
        iss("fl_t0", 4);
        idle("fl_t1");
        iss("fl_t2", 6);
        step("fl_kill", 1, 4, 1, 0, 0, 5, 1, 0, 0, 1);
        check_val("tp_flush", 32'(sbif.pending), 32'h10);
        wbk("fl_wb", 4);

        // Register 0, unused source, stray writebacks
        step("r0", 1, 0, 1, 0, 1, 0, 1, 0, 0, 0);
        check_val("tp_r0", 32'(sbif.pending), 32'h00);
        iss("u_p", 5);
        step("u_rs2", 1, 0, 0, 5, 0, 0, 0, 0, 0, 0);
        wbk("u_wb", 5);
        wbk("wb_np", 3);
        wbk("wb_r0", 0);

        // Asynchronous reset in mid-cycle
        iss("ar1", 1);
        iss("ar2", 2);
        @(negedge Clk);
        sbif.issue_valid   = 1'b1;
        sbif.issue_rs1     = IW'(1);
        sbif.issue_rs1_use = 1'b1;
        #2;
        Rst = 1'b0;
        #1;
        check_val("ar_pend", 32'(sbif.pending), 32'h0);
        check_val("ar_stall", 32'(sbif.stall), 32'h0);
        model_reset();
        clear_inputs();
        @(negedge Clk);
        Rst = 1'b1;
        wbk("ar_wb", 1);

        // Random traffic; the oldest aged entry is always written back so nothing is lost
        for (int k = 0; k < 60; k++) begin
            bit wv;
            int wr;
            int oldest;
            wv = ($urandom_range(0, 2) != 0);
            wr = $urandom_range(0, NR - 1);
            oldest = 2;
            for (int i = 1; i < NR; i++) begin
                if (m_pend[i] != 0 && m_age[i] > oldest) begin
                    oldest = m_age[i];
                    wv = 1'b1;
                    wr = i;
                end
            end
            step($sformatf("rnd%0d", k), $urandom_range(0, 3) != 0,
                 $urandom_range(0, NR - 1), $urandom_range(0, 1) != 0,
                 $urandom_range(0, NR - 1), $urandom_range(0, 1) != 0,
                 $urandom_range(0, NR - 1), $urandom_range(0, 1) != 0,
                 wv, wr, $urandom_range(0, 7) == 0);
        end
        for (int i = 1; i < NR; i++) begin
            if (m_pend[i] != 0) wbk($sformatf("drain%0d", i), i);
        end
        check_val("lost_pre", 32'(sbif.lost_err), 32'h0);

        // Lost writeback: sticky error, entry stays pending
        iss("lost_iss", 1);
        for (int k = 0; k < 6; k++) idle($sformatf("lw%0d", k));
        check_val("lost_early", 32'(sbif.lost_err), 32'h0);
        for (int k = 6; k < 10; k++) idle($sformatf("lw%0d", k));
        check_val("lost_set", 32'(sbif.lost_err), 32'h1);
        check_val("lost_pend", 32'(sbif.pending), 32'h02);
        wbk("lost_wb", 1);
        check_val("lost_sticky", 32'(sbif.lost_err), 32'h1);

`ifdef REG_SCOREBOARD_PERF_EN
        check_val("stall_cnt", sbif.stall_cnt, 32'(m_stall_cnt));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
